mram_cmd_sequencer: RTL and testbench
=====================================

Name: mram_cmd_sequencer

Overview:
Device-side stage directly downstream of the AXI MRAM slave controller. It accepts the controller's single-cycle mram_write_en/mram_read_en strobes, queues them in a small command FIFO and sequences the power-up ramp. It then converts each command into timed chip-enable, write-enable and output-enable pulses on the MRAM macro pins. It returns read data and mram_ready, and generates the mram_pwr_on level the controller gates its chip-select with.

Parameters:
ADDR_WIDTH, 32, byte address width from controller
DATA_WIDTH, 64, data word width (8-byte words)
CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)
PWRUP_CYCLES, 64, cycles from dev_pwr_en rise to mram_pwr_on
WRITE_PULSE, 8, cycles dev_we_n held low per write (>=1)
READ_LAT, 3, cycles dev_oe_n held low before dev_dq_in sampled (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pwr_req  in  1  level request to power the macro
mram_pwr_on  out  1  macro powered and usable
mram_cs  in  1  controller chip select
mram_write_en  in  1  write strobe (1 cycle)
mram_read_en  in  1  read strobe (1 cycle)
mram_addr  in  ADDR_WIDTH  byte address
mram_wdata  in  DATA_WIDTH  write data
mram_rdata  out  DATA_WIDTH  last read data, held
mram_ready  out  1  sequencer idle, FIFO empty, powered
cmd_err  out  1  sticky: overflow, both strobes, or command while off
dev_pwr_en  out  1  macro supply enable
dev_ce_n  out  1  macro chip enable, active low
dev_we_n  out  1  macro write enable, active low
dev_oe_n  out  1  macro output enable, active low
dev_addr  out  ADDR_WIDTH-3  word address = mram_addr[ADDR_WIDTH-1:3]
dev_dq_out  out  DATA_WIDTH  write data to macro
dev_dq_in  in  DATA_WIDTH  read data from macro

Behaviour:
- Reset values: mram_pwr_on=0, mram_rdata=0, mram_ready=0, cmd_err=0, dev_pwr_en=0, dev_ce_n=1, dev_we_n=1, dev_oe_n=1, dev_addr=0, dev_dq_out=0. FIFO is emptied; all FSMs go to their first state.
- Reset mid-operation aborts any pulse immediately (asynchronous). Queued commands are lost.
- Power FSM states: P_OFF, P_RAMP, P_ON, P_DRAIN.
  - P_OFF: when pwr_req=1, dev_pwr_en<=1 and go to P_RAMP.
  - P_RAMP: count 0..PWRUP_CYCLES-1. On terminal count, mram_pwr_on<=1 and go to P_ON. If pwr_req drops during the ramp, go to P_OFF and set dev_pwr_en<=0.
  - P_ON: when pwr_req=0, go to P_DRAIN.
  - P_DRAIN: wait until the FIFO is empty and the sequencer is in S_IDLE. Then set mram_pwr_on<=0 and dev_pwr_en<=0, and go to P_OFF. If pwr_req returns during drain, go back to P_ON.
- Command capture: on a clock edge with mram_cs=1 and exactly one strobe high, push {type, addr, wdata}.
  - Both strobes high: nothing is pushed and cmd_err<=1.
  - FIFO full: the command is dropped and cmd_err<=1.
  - A strobe while mram_pwr_on=0 (including P_RAMP): dropped and cmd_err<=1.
  - cmd_err clears only on reset.
- Sequencer FSM states: S_IDLE, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_RD_ACCESS, S_RD_DONE.
  - S_IDLE: if the FIFO is non-empty, pop the head and load dev_addr/dev_dq_out. Set dev_ce_n<=0 and go to S_WR_SETUP (write) or S_RD_ACCESS (read, dev_oe_n<=0 as well).
  - S_WR_SETUP: 1 cycle. dev_we_n<=0.
  - S_WR_PULSE: WRITE_PULSE cycles with dev_we_n=0, then dev_we_n<=1.
  - S_WR_HOLD: 1 cycle with address and data stable. dev_ce_n<=1, then S_IDLE.
  - S_RD_ACCESS: READ_LAT cycles. On the last cycle mram_rdata<=dev_dq_in, dev_oe_n<=1, dev_ce_n<=1.
  - S_RD_DONE: 1 cycle, then S_IDLE.
- Latency from pop: a write has dev_ce_n low for WRITE_PULSE+2 cycles; a read has dev_ce_n low for READ_LAT cycles. Writes and reads leave through a single FIFO in order, so a read after a write to the same address returns the new data.
- dev_we_n and dev_oe_n are never low in the same cycle. dev_ce_n is always high between commands (at least 1 cycle in S_IDLE or S_RD_DONE).
- mram_ready is registered, and equals mram_pwr_on & FIFO empty & state==S_IDLE & no push this cycle. It falls in the cycle after a push is accepted.
- mram_rdata holds its value until the next read completes. Writes do not change it.
- Simultaneous push and pop on a full FIFO: the push is accepted and cmd_err stays 0.
- FIFO pointers are log2(CMD_DEPTH)+1 bits and wrap naturally. Full = MSBs differ and LSBs equal.

Test Plan:
- Power-up: pwr_req=1 at cycle 0 with PWRUP_CYCLES=64 -> dev_pwr_en=1 at cycle 1; mram_pwr_on and mram_ready =1 at cycle 65; a write strobe issued at cycle 10 sets cmd_err=1 and produces no dev_ce_n pulse.
- Single write: addr=0x40, wdata=0xDEADBEEF_CAFEF00D -> dev_addr=0x8 and dev_dq_out match; dev_we_n low for exactly 8 cycles inside a 10-cycle dev_ce_n low window; mram_ready returns to 1.
- Write-then-read same address: a model macro echoes the stored word -> mram_rdata=0xDEADBEEF_CAFEF00D after dev_oe_n is low for 3 cycles; dev_oe_n and dev_we_n are never low together.
- Overflow: 6 back-to-back write strobes with CMD_DEPTH=4 -> 1 popped immediately and 4 queued, last one dropped; cmd_err=1; exactly 5 write pulses on the pins in order.
- Illegal strobes: write_en=read_en=1 with cs=1 -> no push, cmd_err=1; either strobe with cs=0 -> ignored, cmd_err unchanged.
- Power-down drain plus async reset: drop pwr_req with 3 queued commands -> all 3 complete, then mram_pwr_on=0 and dev_pwr_en=0. Separately, assert rst_n=0 in the middle of S_WR_PULSE -> dev_we_n=1, dev_ce_n=1 and all outputs at reset values the same instant.

Source files
------------

// File: rtl/mram_cmd_sequencer.sv
// mram_cmd_sequencer
//   Sits between the AXI MRAM slave controller and the MRAM macro pins.
//   Single-cycle write/read strobes are queued in a small command FIFO and
//   replayed in order as timed CE/WE/OE pulses. A power FSM ramps the macro
//   supply and holds mram_pwr_on until all queued work has drained.
// Ports
//   clk, rst_n                 clock, async active-low reset
//   pwr_req / mram_pwr_on      power request level / macro usable
//   mram_cs, mram_write_en,
//   mram_read_en, mram_addr,
//   mram_wdata                 controller command side (byte address)
//   mram_rdata, mram_ready     last read word (held) / idle+empty+powered
//   cmd_err                    sticky: overflow, both strobes, cmd while off
//   dev_pwr_en, dev_ce_n,
//   dev_we_n, dev_oe_n,
//   dev_addr, dev_dq_out,
//   dev_dq_in                  macro pins (word address)
module mram_cmd_sequencer #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int CMD_DEPTH    = 4,
  parameter int PWRUP_CYCLES = 64,
  parameter int WRITE_PULSE  = 8,
  parameter int READ_LAT     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pwr_req,
  output logic                  mram_pwr_on,
  input  logic                  mram_cs,
  input  logic                  mram_write_en,
  input  logic                  mram_read_en,
  input  logic [ADDR_WIDTH-1:0] mram_addr,
  input  logic [DATA_WIDTH-1:0] mram_wdata,
  output logic [DATA_WIDTH-1:0] mram_rdata,
  output logic                  mram_ready,
  output logic                  cmd_err,
  output logic                  dev_pwr_en,
  output logic                  dev_ce_n,
  output logic                  dev_we_n,
  output logic                  dev_oe_n,
  output logic [ADDR_WIDTH-4:0] dev_addr,
  output logic [DATA_WIDTH-1:0] dev_dq_out,
  input  logic [DATA_WIDTH-1:0] dev_dq_in
);
  localparam int WAW     = ADDR_WIDTH - 3;
  localparam int PW      = $clog2(CMD_DEPTH);
  localparam int RCW     = $clog2(PWRUP_CYCLES + 1);
  localparam int SEQ_MAX = (WRITE_PULSE > READ_LAT) ? WRITE_PULSE : READ_LAT;
  localparam int SCW     = $clog2(SEQ_MAX + 1);
  localparam logic [RCW-1:0] RAMP_LAST = RCW'(PWRUP_CYCLES - 1);
  localparam logic [SCW-1:0] WP_LAST   = SCW'(WRITE_PULSE - 1);
  localparam logic [SCW-1:0] RL_LAST   = SCW'(READ_LAT - 1);

  typedef struct packed {
    logic                  is_rd;
    logic [WAW-1:0]        addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {P_OFF, P_RAMP, P_ON, P_DRAIN} pstate_t;
  typedef enum logic [2:0] {S_IDLE, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD,
                            S_RD_ACCESS, S_RD_DONE} sstate_t;

  pstate_t p_state, p_nxt;
  sstate_t s_state, s_nxt;

  // byte lane bits never reach the macro
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^mram_addr[2:0];

  // ---------------- command FIFO ----------------
  cmd_t        fifo_mem [CMD_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr, occ, occ_nxt;
  logic        empty, full, one_strobe, push, pop, err_set, drained;
  cmd_t        head, new_cmd;

  assign occ        = wr_ptr - rd_ptr;
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign one_strobe = mram_cs & (mram_write_en ^ mram_read_en);
  assign pop        = (s_state == S_IDLE) & ~empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push       = one_strobe & mram_pwr_on & (~full | pop);
  assign err_set    = (mram_cs & mram_write_en & mram_read_en) | (one_strobe & ~push);
  assign occ_nxt    = occ + (PW+1)'(push) - (PW+1)'(pop);
  assign head       = fifo_mem[rd_ptr[PW-1:0]];
  assign drained    = empty & (s_state == S_IDLE) & ~push;

  assign new_cmd.is_rd = mram_read_en;
  assign new_cmd.addr  = mram_addr[ADDR_WIDTH-1:3];
  assign new_cmd.wdata = mram_wdata;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end

  always_ff @(posedge clk)
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= new_cmd;

  // ---------------- power FSM ----------------
  logic [RCW-1:0] ramp_cnt, ramp_cnt_nxt;
  logic           pwr_en_nxt, pwr_on_nxt;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p_state     <= P_OFF;
      ramp_cnt    <= '0;
      dev_pwr_en  <= 1'b0;
      mram_pwr_on <= 1'b0;
    end else begin
      p_state     <= p_nxt;
      ramp_cnt    <= ramp_cnt_nxt;
      dev_pwr_en  <= pwr_en_nxt;
      mram_pwr_on <= pwr_on_nxt;
    end

  always_comb begin
    p_nxt = p_state;
    case (p_state)
      P_OFF:   if (pwr_req) p_nxt = P_RAMP;
      P_RAMP:  if (!pwr_req) p_nxt = P_OFF;
               else if (ramp_cnt == RAMP_LAST) p_nxt = P_ON;
      P_ON:    if (!pwr_req) p_nxt = P_DRAIN;
      P_DRAIN: if (pwr_req) p_nxt = P_ON;
               else if (drained) p_nxt = P_OFF;
      default: p_nxt = P_OFF;
    endcase
  end

  always_comb begin
    ramp_cnt_nxt = ramp_cnt;
    pwr_en_nxt   = dev_pwr_en;
    pwr_on_nxt   = mram_pwr_on;
    case (p_state)
      P_OFF: if (pwr_req) begin
        pwr_en_nxt   = 1'b1;
        ramp_cnt_nxt = '0;
      end
      P_RAMP:
        if (!pwr_req) pwr_en_nxt = 1'b0;
        else if (ramp_cnt == RAMP_LAST) pwr_on_nxt = 1'b1;
        else ramp_cnt_nxt = ramp_cnt + RCW'(1);
      P_DRAIN: if (!pwr_req && drained) begin
        pwr_on_nxt = 1'b0;
        pwr_en_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // ---------------- sequencer FSM ----------------
  logic [SCW-1:0]        seq_cnt, seq_cnt_nxt;
  logic                  ce_nxt, we_nxt, oe_nxt, ready_nxt;
  logic [WAW-1:0]        addr_nxt;
  logic [DATA_WIDTH-1:0] dq_nxt, rdata_nxt;

  // ready looks at next-state values so it tracks the registered state
  assign ready_nxt = pwr_on_nxt & (occ_nxt == '0) & (s_nxt == S_IDLE);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_state    <= S_IDLE;
      seq_cnt    <= '0;
      dev_ce_n   <= 1'b1;
      dev_we_n   <= 1'b1;
      dev_oe_n   <= 1'b1;
      dev_addr   <= '0;
      dev_dq_out <= '0;
      mram_rdata <= '0;
      mram_ready <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      s_state    <= s_nxt;
      seq_cnt    <= seq_cnt_nxt;
      dev_ce_n   <= ce_nxt;
      dev_we_n   <= we_nxt;
      dev_oe_n   <= oe_nxt;
      dev_addr   <= addr_nxt;
      dev_dq_out <= dq_nxt;
      mram_rdata <= rdata_nxt;
      mram_ready <= ready_nxt;
      cmd_err    <= cmd_err | err_set;
    end

  always_comb begin
    s_nxt = s_state;
    case (s_state)
      S_IDLE:      if (!empty) s_nxt = head.is_rd ? S_RD_ACCESS : S_WR_SETUP;
      S_WR_SETUP:  s_nxt = S_WR_PULSE;
      S_WR_PULSE:  if (seq_cnt == WP_LAST) s_nxt = S_WR_HOLD;
      S_WR_HOLD:   s_nxt = S_IDLE;
      S_RD_ACCESS: if (seq_cnt == RL_LAST) s_nxt = S_RD_DONE;
      S_RD_DONE:   s_nxt = S_IDLE;
      default:     s_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    seq_cnt_nxt = seq_cnt;
    ce_nxt      = dev_ce_n;
    we_nxt      = dev_we_n;
    oe_nxt      = dev_oe_n;
    addr_nxt    = dev_addr;
    dq_nxt      = dev_dq_out;
    rdata_nxt   = mram_rdata;
    case (s_state)
      S_IDLE: if (!empty) begin
        addr_nxt    = head.addr;
        dq_nxt      = head.wdata;
        ce_nxt      = 1'b0;
        seq_cnt_nxt = '0;
        if (head.is_rd) oe_nxt = 1'b0;
      end
      S_WR_SETUP: begin
        we_nxt      = 1'b0;
        seq_cnt_nxt = '0;
      end
      S_WR_PULSE:
        if (seq_cnt == WP_LAST) we_nxt = 1'b1;
        else seq_cnt_nxt = seq_cnt + SCW'(1);
      S_WR_HOLD: ce_nxt = 1'b1;
      S_RD_ACCESS:
        if (seq_cnt == RL_LAST) begin
          rdata_nxt = dev_dq_in;
          oe_nxt    = 1'b1;
          ce_nxt    = 1'b1;
        end else seq_cnt_nxt = seq_cnt + SCW'(1);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mram_cmd_sequencer.sv
// Bench for mram_cmd_sequencer: a command-level reference model (queue +
// "busy until cycle N" bookkeeping) predicts every output each cycle, a
// macro model stores/echoes words, and directed phases pin the model with
// literal values.
module tb_mram_cmd_sequencer;
  localparam int AW = 32, DW = 64, DEPTH = 4, PWRUP = 64, WP = 8, RL = 3;

  logic clk = 1'b0, rst_n = 1'b0, pwr_req = 1'b0, cs = 1'b0, we = 1'b0, re = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0, dq_in = '0;
  logic pwr_on, ready, err, pwr_en, ce_n, we_n, oe_n;
  logic [DW-1:0] rdata, dq_out;
  logic [AW-4:0] daddr;

  always #5 clk = ~clk;

  mram_cmd_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_DEPTH(DEPTH),
    .PWRUP_CYCLES(PWRUP), .WRITE_PULSE(WP), .READ_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n), .pwr_req(pwr_req), .mram_pwr_on(pwr_on),
    .mram_cs(cs), .mram_write_en(we), .mram_read_en(re), .mram_addr(addr),
    .mram_wdata(wdata), .mram_rdata(rdata), .mram_ready(ready), .cmd_err(err),
    .dev_pwr_en(pwr_en), .dev_ce_n(ce_n), .dev_we_n(we_n), .dev_oe_n(oe_n),
    .dev_addr(daddr), .dev_dq_out(dq_out), .dev_dq_in(dq_in));

  int n_checks = 0, n_fail = 0;

  task automatic chk1(string name, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] dflt(logic [AW-4:0] a);
    return 64'h5A5A_0000_0000_0000 | 64'(a);
  endfunction

  // ---------------- macro model (non-volatile, survives reset) ----------------
  logic [DW-1:0] mac_mem [logic [AW-4:0]];
  always @(negedge clk) begin
    if (rst_n && !ce_n && !we_n) mac_mem[daddr] = dq_out;
    if (!oe_n) dq_in = mac_mem.exists(daddr) ? mac_mem[daddr] : dflt(daddr);
    else dq_in = '0;
  end

  // ---------------- pin monitor for directed literal checks ----------------
  int ce_run = 0, we_run = 0, oe_run = 0, last_ce = 0, last_we = 0, last_oe = 0;
  int ce_pulses = 0, wr_pulses = 0;
  logic [AW-4:0] cap_addr, wr_log[$];
  logic [DW-1:0] cap_data;
  always @(negedge clk) begin
    if (!ce_n) ce_run++;
    else if (ce_run > 0) begin last_ce = ce_run; ce_run = 0; ce_pulses++; end
    if (!we_n) begin we_run++; cap_addr = daddr; cap_data = dq_out; end
    else if (we_run > 0) begin last_we = we_run; we_run = 0; wr_pulses++; wr_log.push_back(cap_addr); end
    if (!oe_n) oe_run++;
    else if (oe_run > 0) begin last_oe = oe_run; oe_run = 0; end
  end

  // ---------------- reference model ----------------
  typedef struct { bit rd; logic [AW-4:0] a; logic [DW-1:0] d; } mcmd_t;
  mcmd_t mq[$];
  logic [DW-1:0] ref_mem [logic [AW-4:0]];
  int m_cyc, m_idle_at, m_t, m_rd_at, m_ramp0;
  bit m_rd, m_en, m_on, m_drain, m_err, m_rdy;
  logic [AW-4:0] m_addr;
  logic [DW-1:0] m_dq, m_rdata, m_pend;

  always @(posedge clk or negedge rst_n) begin
    int c;
    bit idle, one, pop, push;
    mcmd_t h;
    if (!rst_n) begin
      mq.delete();
      m_cyc = 0; m_idle_at = 0; m_t = -1000; m_rd_at = -1; m_ramp0 = 0;
      m_rd = 0; m_en = 0; m_on = 0; m_drain = 0; m_err = 0; m_rdy = 0;
      m_addr = '0; m_dq = '0; m_rdata = '0; m_pend = '0;
    end else begin
      c    = m_cyc;
      idle = (c >= m_idle_at);
      one  = cs && (we ^ re);
      pop  = idle && (mq.size() > 0);
      push = one && m_on && ((mq.size() < DEPTH) || pop);
      if ((cs && we && re) || (one && !push)) m_err = 1;
      // power: ramp lasts PWRUP cycles; drain waits for all queued work
      if (!m_en) begin
        if (pwr_req) begin m_en = 1; m_ramp0 = c + 1; end
      end else if (!m_on) begin
        if (!pwr_req) m_en = 0;
        else if (c - m_ramp0 + 1 == PWRUP) m_on = 1;
      end else if (!m_drain) begin
        if (!pwr_req) m_drain = 1;
      end else if (pwr_req) m_drain = 0;
      else if (idle && mq.size() == 0 && !push) begin m_on = 0; m_en = 0; m_drain = 0; end
      if (pop) begin
        h = mq.pop_front();
        m_t = c; m_rd = h.rd; m_addr = h.a; m_dq = h.d;
        if (h.rd) begin
          m_pend    = ref_mem.exists(h.a) ? ref_mem[h.a] : dflt(h.a);
          m_rd_at   = c + RL + 1;
          m_idle_at = c + RL + 2;
        end else begin
          ref_mem[h.a] = h.d;
          m_idle_at    = c + WP + 3;
        end
      end
      if (push) mq.push_back('{re, addr[AW-1:3], wdata});
      m_rdy = m_on && mq.size() == 0 && (c + 1 >= m_idle_at);
      m_cyc = c + 1;
      if (m_cyc == m_rd_at) m_rdata = m_pend;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int c;
    bit e_ce, e_we, e_oe;
    c = m_cyc;
    if (m_rd) begin
      e_ce = !(c >= m_t + 1 && c <= m_t + RL);
      e_oe = e_ce; e_we = 1;
    end else begin
      e_ce = !(c >= m_t + 1 && c <= m_t + WP + 2);
      e_we = !(c >= m_t + 2 && c <= m_t + WP + 1);
      e_oe = 1;
    end
    chk1("dev_ce_n", ce_n, e_ce);
    chk1("dev_we_n", we_n, e_we);
    chk1("dev_oe_n", oe_n, e_oe);
    chk1("we_oe_exclusive", we_n | oe_n, 1'b1);
    chk1("mram_pwr_on", pwr_on, m_on);
    chk1("dev_pwr_en", pwr_en, m_en);
    chk1("mram_ready", ready, m_rdy);
    chk1("cmd_err", err, m_err);
    chkw("dev_addr", 64'(daddr), 64'(m_addr));
    chkw("dev_dq_out", dq_out, m_dq);
    chkw("mram_rdata", rdata, m_rdata);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(bit w, bit r, bit c, logic [AW-1:0] a, logic [DW-1:0] d);
    cs = c; we = w; re = r; addr = a; wdata = d;
    @(negedge clk);
    cs = 0; we = 0; re = 0;
  endtask

  task automatic reset_now();
    #2 rst_n = 1'b0;
    #1;
    chk1("rst_pwr_on", pwr_on, 0); chk1("rst_pwr_en", pwr_en, 0);
    chk1("rst_ready", ready, 0);   chk1("rst_err", err, 0);
    chk1("rst_ce_n", ce_n, 1);     chk1("rst_we_n", we_n, 1);
    chk1("rst_oe_n", oe_n, 1);     chkw("rst_addr", 64'(daddr), 0);
    chkw("rst_dq_out", dq_out, 0); chkw("rst_rdata", rdata, 0);
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    pwr_req = 0; cs = 0; we = 0; re = 0;
    reset_now();
  endtask

  task automatic wait_ready(string name, int bound);
    bit ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      ok = ready;
    end
    chk1(name, ok, 1'b1);
    @(negedge clk);
  endtask

  task automatic power_up();
    pwr_req = 1;
    wait_ready("power_up_timeout", PWRUP + 20);
  endtask

  initial begin
    int base, lbase, k, m;
    bit ok;
    // power-up timing, command while ramping
    do_reset();
    pwr_req = 1;
    base = ce_pulses;
    @(negedge clk);                       // cycle 1
    chk1("pwrup_en_c1", pwr_en, 1); chk1("pwrup_on_c1", pwr_on, 0);
    cyc(9);                               // cycle 10
    strobe(1, 0, 1, 32'h40, 64'h1);       // now cycle 11
    chk1("ramp_cmd_err", err, 1);
    cyc(53);                              // cycle 64
    chk1("pwrup_on_c64", pwr_on, 0);
    @(negedge clk);                       // cycle 65
    chk1("pwrup_on_c65", pwr_on, 1); chk1("pwrup_ready_c65", ready, 1);
    chkw("ramp_cmd_no_ce", 64'(ce_pulses - base), 0);

    // single write, read back, later write leaves rdata alone
    do_reset();
    power_up();
    strobe(1, 0, 1, 32'h40, 64'hDEADBEEF_CAFEF00D);
    wait_ready("wr_done_timeout", 40);
    chkw("wr_ce_len", 64'(last_ce), 10);
    chkw("wr_we_len", 64'(last_we), 8);
    chkw("wr_dev_addr", 64'(cap_addr), 64'h8);
    chkw("wr_dq_out", cap_data, 64'hDEADBEEF_CAFEF00D);
    strobe(0, 1, 1, 32'h40, 64'h0);
    wait_ready("rd_done_timeout", 40);
    chkw("rd_data", rdata, 64'hDEADBEEF_CAFEF00D);
    chkw("rd_oe_len", 64'(last_oe), 3);
    chkw("rd_ce_len", 64'(last_ce), 3);
    strobe(1, 0, 1, 32'h48, 64'h1111_2222_3333_4444);
    wait_ready("wr2_done_timeout", 40);
    chkw("rdata_held", rdata, 64'hDEADBEEF_CAFEF00D);
    chk1("no_err_yet", err, 0);

    // illegal strobes
    base = ce_pulses;
    strobe(1, 0, 0, 32'h40, 64'h0);
    strobe(0, 1, 0, 32'h40, 64'h0);
    cyc(2);
    chk1("cs0_ignored_err", err, 0);
    strobe(1, 1, 1, 32'h40, 64'h0);
    cyc(2);
    chk1("both_strobes_err", err, 1);
    chkw("illegal_no_ce", 64'(ce_pulses - base), 0);

    // overflow: 6 back-to-back writes into a 4-deep FIFO
    do_reset();
    power_up();
    base = wr_pulses; lbase = wr_log.size();
    for (int i = 0; i < 6; i++) strobe(1, 0, 1, 32'h100 + 32'(i * 8), {32'hF0F0_0000, 32'(i)});
    wait_ready("ovf_timeout", 200);
    chkw("ovf_pulses", 64'(wr_pulses - base), 5);
    chk1("ovf_err", err, 1);
    for (int i = 0; i < 5; i++) chkw("ovf_order", 64'(wr_log[lbase + i]), 64'(32 + i));

    // randomized traffic
    do_reset();
    power_up();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) pwr_req = ~pwr_req;
      k = $urandom_range(0, 99);
      if (k < 15) begin
        cs = ($urandom_range(0, 9) != 0);
        m = $urandom_range(0, 9);
        we = (m < 5) || (m == 9);
        re = (m >= 5);
        addr = 32'h200 + 32'($urandom_range(0, 7) * 8) + 32'($urandom_range(0, 7));
        wdata = {$urandom, $urandom};
      end else begin
        cs = 0; we = 0; re = 0;
      end
      @(negedge clk);
    end
    cs = 0; we = 0; re = 0;

    // power-down drain: one in flight plus 3 queued
    do_reset();
    power_up();
    base = wr_pulses;
    for (int i = 0; i < 4; i++) strobe(1, 0, 1, 32'h300 + 32'(i * 8), {32'hABCD_0000, 32'(i)});
    pwr_req = 0;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = !pwr_en;
    end
    chk1("drain_timeout", ok, 1);
    chkw("drain_pulses", 64'(wr_pulses - base), 4);
    chk1("drain_pwr_on", pwr_on, 0);

    // async reset in the middle of a write pulse
    do_reset();
    power_up();
    strobe(1, 0, 1, 32'h500, 64'h5555_AAAA_5555_AAAA);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = !we_n;
    end
    chk1("wr_pulse_seen", ok, 1);
    cyc(3);
    chk1("we_low_before_rst", we_n, 0);
    reset_now();
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
